// File: rtl/bcd_scan_counter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bcd_scan_counter: 4-digit up/down BCD counter with scanned output  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module bcd_scan_counter #(
  parameter int unsigned SCAN_DIV = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        count_en,
  input  logic        up,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic [15:0] count,
  output logic [3:0]  bcd,
  output logic [3:0]  digit_sel,
  output logic        carry,
  output logic        bad_load
);

  localparam logic [15:0] C_PRESC_MAX = 16'(SCAN_DIV - 1);

  logic [15:0] r_count;
  logic [3:0]  r_bcd;
  logic [3:0]  r_digit_sel;
  logic        r_carry;
  logic        r_bad_load;
  logic [15:0] r_presc;
  logic [1:0]  r_idx;

  logic [15:0] w_inc;
  logic [15:0] w_dec;
  logic        w_inc_wrap;
  logic        w_dec_wrap;
  logic        w_load_ok;
  logic [3:0]  w_cur_digit;

  // Ripple chains: a wrap flag still set after the top digit means 9999->0000 or 0000->9999.
  always_comb begin
    w_inc      = r_count;
    w_dec      = r_count;
    w_inc_wrap = 1'b1;
    w_dec_wrap = 1'b1;
    w_load_ok  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (w_inc_wrap) begin
        if (r_count[4*i +: 4] == 4'd9) begin
          w_inc[4*i +: 4] = 4'd0;
        end else begin
          w_inc[4*i +: 4] = r_count[4*i +: 4] + 4'd1;
          w_inc_wrap      = 1'b0;
        end
      end
      if (w_dec_wrap) begin
        if (r_count[4*i +: 4] == 4'd0) begin
          w_dec[4*i +: 4] = 4'd9;
        end else begin
          w_dec[4*i +: 4] = r_count[4*i +: 4] - 4'd1;
          w_dec_wrap      = 1'b0;
        end
      end
      if (load_val[4*i +: 4] > 4'd9) begin
        w_load_ok = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count    <= 16'h0000;
      r_carry    <= 1'b0;
      r_bad_load <= 1'b0;
    end else begin
      r_carry    <= 1'b0;
      r_bad_load <= 1'b0;
      if (load) begin
        if (w_load_ok) begin
          r_count <= load_val;
        end else begin
          r_bad_load <= 1'b1;
        end
      end else if (count_en) begin
        if (up) begin
          r_count <= w_inc;
          r_carry <= w_inc_wrap;
        end else begin
          r_count <= w_dec;
          r_carry <= w_dec_wrap;
        end
      end
    end
  end

  always_comb begin
    w_cur_digit = r_count[3:0];
    case (r_idx)
      2'd0: w_cur_digit = r_count[3:0];
      2'd1: w_cur_digit = r_count[7:4];
      2'd2: w_cur_digit = r_count[11:8];
      2'd3: w_cur_digit = r_count[15:12];
      default: w_cur_digit = r_count[3:0];
    endcase
  end

  // Display registers sample the pre-edge count and index, so they trail by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc     <= 16'h0000;
      r_idx       <= 2'd0;
      r_digit_sel <= 4'b0001;
      r_bcd       <= 4'd0;
    end else begin
      if (r_presc == C_PRESC_MAX) begin
        r_presc <= 16'h0000;
        r_idx   <= r_idx + 2'd1;
      end else begin
        r_presc <= r_presc + 16'h0001;
      end
      r_digit_sel <= 4'b0001 << r_idx;
      r_bcd       <= w_cur_digit;
    end
  end

  assign count     = r_count;
  assign bcd       = r_bcd;
  assign digit_sel = r_digit_sel;
  assign carry     = r_carry;
  assign bad_load  = r_bad_load;

endmodule
`default_nettype wire
